// File: rtl/cga_outmux_if.sv
// rtl/cga_outmux_if.sv - CGA analog output selector bus: DAC/composite levels in, selected levels out
interface cga_outmux_if #(
   parameter int RED_W  = 6,
   parameter int GRN_W  = 7,
   parameter int BLU_W  = 6,
   parameter int COMP_W = 7
);
   logic [RED_W-1:0]  rgb_red;
   logic [GRN_W-1:0]  rgb_green;
   logic [BLU_W-1:0]  rgb_blue;
   logic [COMP_W-1:0] comp_video;
   logic              hsync_in;
   logic              vsync_in;
   logic              sw_comp;
   logic              sw_mono;
   logic [RED_W-1:0]  red;
   logic [GRN_W-1:0]  green;
   logic [BLU_W-1:0]  blue;
   logic              hsync_out;
   logic              vsync_out;
   logic [1:0]        mode;
   logic              blanking;

   // Driver side: video source, syncs and config switches
   modport master (
      output rgb_red, rgb_green, rgb_blue, comp_video, hsync_in, vsync_in, sw_comp, sw_mono,
      input  red, green, blue, hsync_out, vsync_out, mode, blanking
   );

   // Selector side
   modport slave (
      input  rgb_red, rgb_green, rgb_blue, comp_video, hsync_in, vsync_in, sw_comp, sw_mono,
      output red, green, blue, hsync_out, vsync_out, mode, blanking
   );
endinterface

// File: rtl/cga_outmux.sv
// rtl/cga_outmux.sv - registered RGB/composite/mono output selector with vsync-aligned blanked mode changes (optional mono via CGA_OUTMUX_MONO_EN)
module cga_outmux #(
   parameter int          RED_W        = 6,
   parameter int          GRN_W        = 7,
   parameter int          BLU_W        = 6,
   parameter int          COMP_W       = 7,
   parameter logic [15:0] DEB_MAX      = 16'd50000,
   parameter int          BLANK_FRAMES = 2
) (
   input  logic         clk,
   input  logic         reset_l,
   cga_outmux_if.slave  bus
);

   localparam logic [1:0]  MODE_RGB   = 2'b00;
   localparam logic [1:0]  MODE_COMP  = 2'b01;
   localparam logic [1:0]  MODE_MONO  = 2'b10;
   localparam logic [15:0] DEB_LAST   = DEB_MAX - 16'd1;
   localparam logic [3:0]  BLANK_LOAD = 4'(BLANK_FRAMES);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   // ---------------------------------------------------------------
   // Switch synchronisers and candidate decode
   // ---------------------------------------------------------------
   logic       comp_s1_q, comp_s2_q;
   logic [1:0] cand;

   // Two-flop synchroniser for the composite switch
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         comp_s1_q <= 1'b0;
         comp_s2_q <= 1'b0;
      end else begin
         comp_s1_q <= bus.sw_comp;
         comp_s2_q <= comp_s1_q;
      end
   end

`ifdef CGA_OUTMUX_MONO_EN
   logic mono_s1_q, mono_s2_q;

   // Two-flop synchroniser for the mono switch
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         mono_s1_q <= 1'b0;
         mono_s2_q <= 1'b0;
      end else begin
         mono_s1_q <= bus.sw_mono;
         mono_s2_q <= mono_s1_q;
      end
   end

   // Composite wins over mono when both switches are set
   always_comb begin
      cand = MODE_RGB;
      if (comp_s2_q)      cand = MODE_COMP;
      else if (mono_s2_q) cand = MODE_MONO;
   end
`else
   logic unused_sw_mono;
   assign unused_sw_mono = bus.sw_mono;

   // Without mono support the switch choice is composite or RGB only
   always_comb begin
      cand = MODE_RGB;
      if (comp_s2_q) cand = MODE_COMP;
   end
`endif

   // ---------------------------------------------------------------
   // Debounce: candidate must differ from deb_mode for DEB_MAX cycles
   // ---------------------------------------------------------------
   logic [15:0] deb_cnt_q, deb_cnt_d;
   logic [1:0]  deb_mode_q, deb_mode_d;

   // Count consecutive disagreement; adopt the candidate on the last count
   always_comb begin
      deb_cnt_d  = 16'd0;
      deb_mode_d = deb_mode_q;
      if (cand != deb_mode_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            deb_mode_d = cand;
            deb_cnt_d  = 16'd0;
         end else begin
            deb_cnt_d = deb_cnt_q + 16'd1;
         end
      end
   end

   // Debounce state registers
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         deb_cnt_q  <= 16'd0;
         deb_mode_q <= MODE_RGB;
      end else begin
         deb_cnt_q  <= deb_cnt_d;
         deb_mode_q <= deb_mode_d;
      end
   end

   // ---------------------------------------------------------------
   // Mode-change FSM
   // ---------------------------------------------------------------
   state_t     state_q, state_d;
   logic [1:0] mode_q, mode_d;
   logic [3:0] frame_cnt_q, frame_cnt_d;
   logic       vs_prev_q;
   logic       vs_rise;

   assign vs_rise = bus.vsync_in & ~vs_prev_q;

   // Next state: commit only on a vsync edge, then blank whole frames.
   // The FSM looks at the registered deb_mode, so a debounce update that
   // coincides with vs_rise is picked up on a later frame.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      frame_cnt_d = frame_cnt_q;
      unique case (state_q)
         ST_RUN: begin
            if (deb_mode_q != mode_q) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (deb_mode_q == mode_q) begin
               state_d = ST_RUN;
            end else if (vs_rise) begin
               mode_d      = deb_mode_q;
               frame_cnt_d = BLANK_LOAD;
               state_d     = (BLANK_FRAMES == 0) ? ST_RUN : ST_BLANK;
            end
         end
         ST_BLANK: begin
            if (vs_rise) begin
               frame_cnt_d = frame_cnt_q - 4'd1;
               if (frame_cnt_q == 4'd1) state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // FSM registers and the previous-vsync sample used for edge detect
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q     <= ST_RUN;
         mode_q      <= MODE_RGB;
         frame_cnt_q <= 4'd0;
         vs_prev_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         frame_cnt_q <= frame_cnt_d;
         vs_prev_q   <= bus.vsync_in;
      end
   end

   // ---------------------------------------------------------------
   // Level mapping: composite luma MSB-aligned onto each channel width
   // ---------------------------------------------------------------
   logic [RED_W-1:0] conv_red;
   logic [GRN_W-1:0] conv_grn;
   logic [BLU_W-1:0] conv_blu;

   generate
      if (COMP_W >= RED_W) begin : g_red_trunc
         assign conv_red = bus.comp_video[COMP_W-1 -: RED_W];
      end else begin : g_red_pad
         assign conv_red = {bus.comp_video, {(RED_W-COMP_W){1'b0}}};
      end
      if (COMP_W >= GRN_W) begin : g_grn_trunc
         assign conv_grn = bus.comp_video[COMP_W-1 -: GRN_W];
      end else begin : g_grn_pad
         assign conv_grn = {bus.comp_video, {(GRN_W-COMP_W){1'b0}}};
      end
      if (COMP_W >= BLU_W) begin : g_blu_trunc
         assign conv_blu = bus.comp_video[COMP_W-1 -: BLU_W];
      end else begin : g_blu_pad
         assign conv_blu = {bus.comp_video, {(BLU_W-COMP_W){1'b0}}};
      end
   endgenerate

   logic [RED_W-1:0] red_q, red_d;
   logic [GRN_W-1:0] grn_q, grn_d;
   logic [BLU_W-1:0] blu_q, blu_d;
   logic             hs_q, vs_q;

   // Levels follow the next state/mode so blanking and the new mode
   // appear on the output pins on the same edge as the commit
   always_comb begin
      red_d = '0;
      grn_d = '0;
      blu_d = '0;
      if (state_d != ST_BLANK) begin
         case (mode_d)
            MODE_COMP: begin
               grn_d = conv_grn;
            end
            MODE_MONO: begin
               red_d = conv_red;
               grn_d = conv_grn;
               blu_d = conv_blu;
            end
            default: begin
               red_d = bus.rgb_red;
               grn_d = bus.rgb_green;
               blu_d = bus.rgb_blue;
            end
         endcase
      end
   end

   // Output registers: levels and syncs share one cycle of latency
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         red_q <= '0;
         grn_q <= '0;
         blu_q <= '0;
         hs_q  <= 1'b0;
         vs_q  <= 1'b0;
      end else begin
         red_q <= red_d;
         grn_q <= grn_d;
         blu_q <= blu_d;
         hs_q  <= bus.hsync_in;
         vs_q  <= bus.vsync_in;
      end
   end

   assign bus.red       = red_q;
   assign bus.green     = grn_q;
   assign bus.blue      = blu_q;
   assign bus.hsync_out = hs_q;
   assign bus.vsync_out = vs_q;
   assign bus.blanking  = (state_q == ST_BLANK);
`ifdef CGA_OUTMUX_MONO_EN
   assign bus.mode      = mode_q;
`else
   assign bus.mode      = {1'b0, mode_q[0]};
`endif

endmodule

// File: tb/tb_cga_outmux.sv
// tb/tb_cga_outmux.sv - directed self-checking bench for cga_outmux (mono checks follow CGA_OUTMUX_MONO_EN)
module tb_cga_outmux;

   logic clk = 1'b0;
   logic reset_l;
   int   compares = 0;
   int   fails    = 0;
   logic seen_blank;

   always #5 clk = ~clk;

   cga_outmux_if #(.RED_W(6), .GRN_W(7), .BLU_W(6), .COMP_W(7)) bus ();

   cga_outmux #(
      .RED_W(6), .GRN_W(7), .BLU_W(6), .COMP_W(7),
      .DEB_MAX(16'd4), .BLANK_FRAMES(2)
   ) dut (
      .clk(clk),
      .reset_l(reset_l),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compares++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic vs_high();
      bus.vsync_in = 1'b1;
      step(1);
   endtask

   task automatic vs_low();
      bus.vsync_in = 1'b0;
      step(3);
   endtask

   initial begin
      reset_l        = 1'b0;
      bus.rgb_red    = 6'h2A;
      bus.rgb_green  = 7'h11;
      bus.rgb_blue   = 6'h15;
      bus.comp_video = 7'h55;
      bus.hsync_in   = 1'b0;
      bus.vsync_in   = 1'b0;
      bus.sw_comp    = 1'b0;
      bus.sw_mono    = 1'b0;
      step(3);

      // reset state
      check("rst_red",      16'(bus.red), 16'h0);
      check("rst_green",    16'(bus.green), 16'h0);
      check("rst_mode",     16'(bus.mode), 16'h0);
      check("rst_blanking", 16'(bus.blanking), 16'h0);
      check("rst_vsync",    16'(bus.vsync_out), 16'h0);

      // first cycle after release: RGB passthrough, sync latency
      reset_l      = 1'b1;
      bus.hsync_in = 1'b1;
      step(1);
      check("rgb_red",   16'(bus.red), 16'h2A);
      check("rgb_green", 16'(bus.green), 16'h11);
      check("rgb_blue",  16'(bus.blue), 16'h15);
      check("rgb_hsync", 16'(bus.hsync_out), 16'h1);
      check("rgb_mode",  16'(bus.mode), 16'h0);
      bus.hsync_in = 1'b0;
      step(1);
      check("hsync_fall", 16'(bus.hsync_out), 16'h0);

      // 3-cycle glitch on sw_comp is shorter than DEB_MAX
      bus.sw_comp = 1'b1;
      step(3);
      bus.sw_comp = 1'b0;
      seen_blank = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         seen_blank = seen_blank | bus.blanking;
      end
      vs_high();
      check("glitch_mode",  16'(bus.mode), 16'h0);
      check("glitch_blank", 16'(seen_blank | bus.blanking), 16'h0);
      vs_low();

      // enter WAIT, then return to RGB before any vsync
      bus.sw_comp = 1'b1;
      step(8);
      check("wait_mode", 16'(bus.mode), 16'h0);
      bus.sw_comp = 1'b0;
      seen_blank = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         seen_blank = seen_blank | bus.blanking;
      end
      vs_high();
      check("abort_mode",  16'(bus.mode), 16'h0);
      check("abort_blank", 16'(seen_blank | bus.blanking), 16'h0);
      check("abort_red",   16'(bus.red), 16'h2A);
      vs_low();

      // hold composite; commit on first vsync, blank two frames
      bus.sw_comp = 1'b1;
      step(10);
      check("pre_commit_mode",  16'(bus.mode), 16'h0);
      check("pre_commit_blank", 16'(bus.blanking), 16'h0);
      vs_high();
      check("commit_mode",   16'(bus.mode), 16'h1);
      check("commit_blank",  16'(bus.blanking), 16'h1);
      check("commit_red",    16'(bus.red), 16'h0);
      check("commit_green",  16'(bus.green), 16'h0);
      check("commit_blue",   16'(bus.blue), 16'h0);
      check("commit_vsync",  16'(bus.vsync_out), 16'h1);
      vs_low();
      vs_high();
      check("frame2_blank", 16'(bus.blanking), 16'h1);
      check("frame2_green", 16'(bus.green), 16'h0);
      vs_low();
      vs_high();
      check("comp_blank", 16'(bus.blanking), 16'h0);
      check("comp_green", 16'(bus.green), 16'h55);
      check("comp_red",   16'(bus.red), 16'h0);
      check("comp_blue",  16'(bus.blue), 16'h0);
      check("comp_mode",  16'(bus.mode), 16'h1);
      vs_low();

      // mono switch: mono mode when built in, otherwise falls back to RGB
      bus.sw_comp = 1'b0;
      bus.sw_mono = 1'b1;
      step(10);
      check("pre_mono_mode", 16'(bus.mode), 16'h1);
      vs_high();
      check("mono_commit_blank", 16'(bus.blanking), 16'h1);
      vs_low();
      vs_high();
      vs_low();
      vs_high();
      check("mono_blank_done", 16'(bus.blanking), 16'h0);
`ifdef CGA_OUTMUX_MONO_EN
      check("mono_mode",  16'(bus.mode), 16'h2);
      check("mono_red",   16'(bus.red), 16'h2A);
      check("mono_green", 16'(bus.green), 16'h55);
      check("mono_blue",  16'(bus.blue), 16'h2A);
`else
      check("nomono_mode",  16'(bus.mode), 16'h0);
      check("nomono_red",   16'(bus.red), 16'h2A);
      check("nomono_green", 16'(bus.green), 16'h11);
      check("nomono_blue",  16'(bus.blue), 16'h15);
`endif
      vs_low();

      // reset during BLANK, then recover with sw_comp still held
      bus.sw_mono = 1'b0;
      bus.sw_comp = 1'b1;
      step(10);
      vs_high();
      check("pre_reset_blank", 16'(bus.blanking), 16'h1);
      check("pre_reset_mode",  16'(bus.mode), 16'h1);
      bus.vsync_in = 1'b0;
      step(1);
      reset_l = 1'b0;
      #1;
      check("async_mode",  16'(bus.mode), 16'h0);
      check("async_blank", 16'(bus.blanking), 16'h0);
      check("async_green", 16'(bus.green), 16'h0);
      step(2);
      reset_l = 1'b1;
      step(10);
      check("rerun_mode",  16'(bus.mode), 16'h0);
      check("rerun_blank", 16'(bus.blanking), 16'h0);
      check("rerun_red",   16'(bus.red), 16'h2A);
      vs_high();
      check("reblank_mode",  16'(bus.mode), 16'h1);
      check("reblank_blank", 16'(bus.blanking), 16'h1);
      check("reblank_red",   16'(bus.red), 16'h0);
      vs_low();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end

endmodule
